// File: rtl/spi_arb_pkg.sv
// Shared types and SPI mode constants for the peripheral SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MCU,
    INT_SETUP,
    INT_SHIFT,
    INT_HOLD,
    GUARD
  } arb_state_t;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b1;

endpackage

// File: rtl/sync_fall_edge.sv
// Two-flop synchronizer for an active-low asynchronous input, with falling-edge pulse.
module sync_fall_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '1;
    else        sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign fall  = sr[2] & ~sr[1];

endmodule

// File: rtl/spi_bus_arbiter.sv
// Arbitrates the peripheral SPI bus between MCU pass-through and an internal ADC reader.
// Optional SPI_ARB_OVERRUN_CNT_EN enables the saturating overrun counter on ovr_count.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned FRAME_BITS   = 24,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mcu_cs_n,
  input  logic                  drdy_n,
  input  logic                  miso,
  input  logic [FRAME_BITS-1:0] cmd_word,
  input  logic                  clr_overrun,
  output logic                  grant_mcu,
  output logic                  mcu_busy,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic [FRAME_BITS-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  overrun,
  output logic [7:0]            ovr_count
);

  localparam int unsigned CW = $clog2(CLK_DIV + GUARD_CYCLES + 1);
  localparam int unsigned EW = $clog2(2 * FRAME_BITS);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * FRAME_BITS - 1);

  arb_state_t state, state_n;
  logic mcu_level, mcu_fall, drdy_fall, drdy_level_unused;
  logic mcu_req, pending, take, ovr_evt, div_tick;
  logic [CW-1:0] cnt;
  logic [EW-1:0] ecnt;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr;

  sync_fall_edge u_sync_mcu (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mcu_cs_n),
    .level (mcu_level),
    .fall  (mcu_fall)
  );

  sync_fall_edge u_sync_drdy (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (drdy_n),
    .level (drdy_level_unused),
    .fall  (drdy_fall)
  );

  assign div_tick = (cnt == DIV_LAST);
  assign take     = (state == IDLE) && pending;
  assign ovr_evt  = drdy_fall && pending && !take;

  // mcu_req lags the synchronized level by one flop so it lines up with pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcu_req <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (mcu_fall)       mcu_req <= 1'b1;
      else if (mcu_level) mcu_req <= 1'b0;
      if (take)           pending <= drdy_fall;
      else if (drdy_fall) pending <= 1'b1;
      if (ovr_evt)          overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef SPI_ARB_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_cnt <= '0;
    else if (ovr_evt) begin
      if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end else if (clr_overrun) ovr_cnt <= '0;
  end
  assign ovr_count = ovr_cnt;
`else
  assign ovr_count = '0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (pending) state_n = INT_SETUP;
                 else if (mcu_req) state_n = MCU;
      MCU:       if (!mcu_req) state_n = GUARD;
      INT_SETUP: if (div_tick) state_n = INT_SHIFT;
      INT_SHIFT: if (div_tick && ecnt == EDGE_LAST) state_n = INT_HOLD;
      INT_HOLD:  if (div_tick) state_n = GUARD;
      GUARD:     if (cnt == GUARD_LAST) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || (state == INT_SHIFT && div_tick)) cnt <= '0;
      else if (state == IDLE || state == MCU)                   cnt <= '0;
      else                                                      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n      <= 1'b1;
      sclk      <= CPOL;
      mosi      <= 1'b0;
      grant_mcu <= 1'b0;
      mcu_busy  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      ecnt      <= '0;
    end else begin
      rd_valid  <= 1'b0;
      grant_mcu <= (state_n == MCU);
      mcu_busy  <= ~mcu_level & (state_n != MCU);
      case (state)
        IDLE: if (state_n == INT_SETUP) begin
          cs_n  <= 1'b0;
          tx_sr <= cmd_word;
          mosi  <= cmd_word[FRAME_BITS-1];
          ecnt  <= '0;
        end
        INT_SETUP: if (div_tick) begin
          sclk  <= ~CPOL;
          mosi  <= tx_sr[FRAME_BITS-1];
          tx_sr <= tx_sr << 1;
        end
        // Leading edge launches the next bit; no leading edge after the final trailing edge
        INT_SHIFT: if (div_tick) begin
          ecnt <= ecnt + EW'(1);
          if (sclk != CPOL) begin
            sclk  <= CPOL;
            rx_sr <= {rx_sr[FRAME_BITS-2:0], miso};
          end else if (ecnt != EDGE_LAST) begin
            sclk  <= ~CPOL;
            mosi  <= tx_sr[FRAME_BITS-1];
            tx_sr <= tx_sr << 1;
          end
        end
        INT_HOLD: if (div_tick) begin
          cs_n     <= 1'b1;
          mosi     <= 1'b0;
          rd_data  <= rx_sr;
          rd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Arbitrates the shared peripheral SPI bus (ADC, DAC, 4094 chain, flash) between two requesters. One requester is the MCU pass-through, framed by the MCU's second chip-select. The other is an internal autonomous master that reads the ADC on every data-ready falling edge. The block owns the internal master's SCLK/MOSI/CS_n generation and MISO capture, and drives a grant signal that the top-level chip-select and MISO muxes use to connect the bus to the MCU.

## Interface
- CLK_DIV, 2, clk cycles per SCLK half-period (≥1)
- FRAME_BITS, 24, bits per internal frame (2..32)
- GUARD_CYCLES, 4, idle clk cycles between any two bus owners (≥1)
- clk  in  1  system clock (XTALCLK domain)
- rst_n  in  1  asynchronous, active-low reset
- mcu_cs_n  in  1  MCU bus request, active low, asynchronous to clk
- drdy_n  in  1  ADC data-ready, active low, asynchronous
- miso  in  1  shared bus MISO, already muxed to the selected ADC
- cmd_word  in  FRAME_BITS  word shifted out MSB-first on each internal frame; sampled at frame start
- clr_overrun  in  1  synchronous clear of overrun and ovr_count
- grant_mcu  out  1  bus connected to MCU pass-through
- mcu_busy  out  1  MCU is requesting but not granted (MCU must hold mcu_cs_n low and wait)
- sclk, mosi, cs_n  out  1 each  internal master bus signals
- rd_data  out  FRAME_BITS  last captured frame
- rd_valid  out  1  one-cycle pulse when rd_data updates
- overrun  out  1  sticky flag: data-ready lost
- ovr_count  out  8  saturating overrun count (see Configuration)

## Operation
- mcu_cs_n and drdy_n each pass through a 2-flop synchronizer. A falling edge on synchronized drdy_n sets `pending`.
- States and transitions:
  - IDLE → INT_SETUP if `pending`. Otherwise IDLE → MCU if synchronized mcu_cs_n is low.
  - MCU → GUARD when synchronized mcu_cs_n goes high.
  - INT_SETUP → INT_SHIFT after CLK_DIV cycles.
  - INT_SHIFT → INT_HOLD after FRAME_BITS SCLK periods.
  - INT_HOLD → GUARD after CLK_DIV cycles.
  - GUARD → IDLE after GUARD_CYCLES cycles.
- Entering INT_SETUP: cs_n goes low, `pending` is cleared, cmd_word is loaded into the TX shifter, and mosi presents the MSB.
- INT_SHIFT uses SPI mode 1 (CPOL=0, CPHA=1):
  - sclk rises and mosi shifts on each rising edge.
  - miso is sampled into the RX shifter on each falling edge.
  - Exactly FRAME_BITS rising and FRAME_BITS falling edges occur.
- Leaving INT_HOLD: cs_n goes high, rd_data is loaded, and rd_valid pulses for 1 cycle.
- grant_mcu is high only in state MCU.
- mcu_busy = synchronized mcu_cs_n low AND state ≠ MCU.
- Simultaneous requests in IDLE: the internal request wins, because ADC data has a deadline.
- The MCU is never preempted. A data-ready edge during MCU sets `pending`, which is served after MCU → GUARD → IDLE.
- A data-ready edge while `pending` is already set: overrun is set, and `pending` stays a single request (no queue).
- A data-ready edge during INT_SETUP/SHIFT/HOLD sets `pending`. It is served after GUARD.
- If clr_overrun and an overrun event occur in the same cycle, the set wins.
- Reset (any state, mid-frame included) forces the following values:
  - state IDLE, `pending` 0;
  - cs_n 1, sclk 0, mosi 0;
  - grant_mcu 0, mcu_busy 0;
  - rd_data 0, rd_valid 0;
  - overrun 0, ovr_count 0.

## Timing
- drdy_n is first sampled low at clk edge k:
  - `pending` is set at k+2;
  - cs_n goes low at k+3, when the block is in IDLE.
- An internal frame lasts CLK_DIV + 2·CLK_DIV·FRAME_BITS + CLK_DIV cycles. With the defaults this is 100 cycles.
- mcu_cs_n is first sampled low at edge k with the block in IDLE and nothing pending: grant_mcu goes high at k+3.
- mcu_cs_n is first sampled high at edge k in state MCU: grant_mcu goes low at k+3, then GUARD runs for GUARD_CYCLES.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SPI_ARB_OVERRUN_CNT_EN:
  - Defined: ovr_count increments on every overrun event, saturates at 255, and is cleared by clr_overrun.
  - Undefined: the ovr_count port remains but is tied to 0, and the counter logic is absent.

## Structure
- Package spi_arb_pkg holds:
  - the state enum (IDLE, MCU, INT_SETUP, INT_SHIFT, INT_HOLD, GUARD);
  - the SPI mode constants CPOL=0 and CPHA=1.
- Sub-module sync_fall_edge: 2-flop synchronizer plus falling-edge detect, with outputs level and fall pulse. It is instantiated twice, for mcu_cs_n and drdy_n.

## Test plan
- drdy_n falling, cmd_word=24'hA5A5A5, miso driven by a 24'h123456 slave model → mosi carries A5A5A5 MSB-first, rd_data=24'h123456, rd_valid pulses once, cs_n low for exactly 100 cycles.
- mcu_cs_n low for 50 cycles from IDLE → grant_mcu high 3 cycles after, low 3 cycles after release, then 4 GUARD cycles before any new owner.
- drdy_n falling 10 cycles into an MCU hold → mcu session completes untouched, then an internal frame starts at the first IDLE cycle after GUARD, with overrun=0.
- Two drdy_n falling edges during one MCU hold → overrun=1 and exactly one internal frame; with the macro defined, ovr_count=1.
- mcu_cs_n and drdy_n falling on the same edge → internal frame first, mcu_busy=1 until grant, then grant_mcu=1.
- rst_n low at bit 12 of an internal frame → all outputs at reset values immediately, no rd_valid, next drdy_n edge starts a clean frame.
